tristate_bus_arbiter: RTL and testbench

//  Shares one tristate bus between N_REQ drivers, each a trisbuf instance whose Enable this block owns.
//  - Arbitration is round-robin.
//  - At most one Enable is ever high.
//  - A break-before-make turnaround of GAP cycles (all Enables low) separates successive owners.
//  - Ownership is capped at HOLD_MAX cycles so no driver can starve the others.

---
 rtl/tristate_bus_arbiter_pkg.sv | 16 +
 rtl/tristate_bus_arbiter_rr_pick.sv | 34 +++
 rtl/tristate_bus_arbiter.sv | 97 +++++++++
 tb/tb_tristate_bus_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and helpers for the tristate bus arbiter: FSM state encoding
// and an index-width function that never returns zero.
package tristate_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    // Width needed to index n items; 1 bit minimum so ports never collapse to zero width.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping N_REQ-1 -> 0. Works for any N_REQ, not only powers of two.
module rr_pick
    import tristate_bus_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             found_o,
    output logic [PTR_W-1:0] winner_o
);

    logic [PTR_W:0] idx;

    // Scan offsets from farthest to nearest so the closest set request wins.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_i} + (PTR_W + 1)'(i);
            if (idx >= (PTR_W + 1)'(N_REQ)) begin
                idx = idx - (PTR_W + 1)'(N_REQ);
            end
            if (req_i[idx[PTR_W-1:0]]) begin
                found_o  = 1'b1;
                winner_o = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of the trisbuf Enables on a shared bus, with a capped
// hold time and a GAP-cycle all-off turnaround between successive owners.
module tristate_bus_arbiter
    import tristate_bus_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 8,
    parameter int GAP      = 1,
    parameter int PTR_W    = clog2_min1(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] request_i,
    output logic [N_REQ-1:0] enable_o,
    output logic [PTR_W-1:0] owner_o,
    output logic             bus_busy_o
);

    localparam int HOLD_W = clog2_min1(HOLD_MAX + 1);
    localparam int GAP_W  = clog2_min1(GAP + 1);

    arb_state_t        state_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [HOLD_W-1:0] hold_q;
    logic [GAP_W-1:0]  gap_q;
    logic [N_REQ-1:0]  enable_q;
    logic [PTR_W-1:0]  owner_q;
    logic              busy_q;

    logic              pick_found;
    logic [PTR_W-1:0]  pick_winner;
    logic [PTR_W-1:0]  ptr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i    (request_i),
        .ptr_i    (ptr_q),
        .found_o  (pick_found),
        .winner_o (pick_winner)
    );

    // Pointer moves past the releasing owner so others win the next round.
    assign ptr_next = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    // NOTE: all state and outputs update with non-blocking assignments so every
    // register sees pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            hold_q   <= '0;
            gap_q    <= '0;
            enable_q <= '0;
            owner_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, TURN: begin
                    if (state_q == TURN && gap_q < GAP_W'(GAP)) begin
                        gap_q <= gap_q + 1'b1;
                    end else if (pick_found) begin
                        enable_q <= N_REQ'(1) << pick_winner;
                        owner_q  <= pick_winner;
                        busy_q   <= 1'b1;
                        hold_q   <= HOLD_W'(1);
                        state_q  <= OWN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                OWN: begin
                    if (request_i[owner_q] && hold_q < HOLD_W'(HOLD_MAX)) begin
                        hold_q <= hold_q + 1'b1;
                    end else begin
                        enable_q <= '0;
                        busy_q   <= 1'b0;
                        ptr_q    <= ptr_next;
                        gap_q    <= GAP_W'(1);
                        state_q  <= TURN;
                    end
                end
                default: begin
                    enable_q <= '0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign enable_o   = enable_q;
    assign owner_o    = owner_q;
    assign bus_busy_o = busy_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter: a vector table for reset/single
// request/reset-mid-ownership, plus sequences for rotation, hogging and GAP=3.
module tb_tristate_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] request = '0;
    logic [3:0] enable;
    logic [1:0] owner;
    logic       busy;

    logic       rst_g = 1'b1;
    logic [3:0] request_g = '0;
    logic [3:0] enable_g;
    logic [1:0] owner_g;
    logic       busy_g;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tristate_bus_arbiter #(.N_REQ(4), .HOLD_MAX(8), .GAP(1)) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .request_i  (request),
        .enable_o   (enable),
        .owner_o    (owner),
        .bus_busy_o (busy)
    );

    tristate_bus_arbiter #(.N_REQ(4), .HOLD_MAX(8), .GAP(3)) u_dut_gap3 (
        .clk_i      (clk),
        .rst_i      (rst_g),
        .request_i  (request_g),
        .enable_o   (enable_g),
        .owner_o    (owner_g),
        .bus_busy_o (busy_g)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Invariants on both instances, sampled mid-cycle.
    logic [3:0] prev_en = '0;
    logic [3:0] prev_en_g = '0;
    always @(negedge clk) begin
        check("onehot0", 32'($onehot0(enable)), 1);
        check("busy_eq_or", 32'(busy), 32'(|enable));
        check("break_before_make", 32'(prev_en != 0 && enable != 0 && prev_en != enable), 0);
        check("g3 onehot0", 32'($onehot0(enable_g)), 1);
        check("g3 busy_eq_or", 32'(busy_g), 32'(|enable_g));
        check("g3 break_before_make", 32'(prev_en_g != 0 && enable_g != 0 && prev_en_g != enable_g), 0);
        prev_en   = enable;
        prev_en_g = enable_g;
    end

    task automatic apply(input string tag, input logic r, input logic [3:0] req,
                         input logic [3:0] exp_en, input logic [1:0] exp_own);
        rst     = r;
        request = req;
        @(posedge clk);
        #1;
        check({tag, " enable"}, 32'(enable), 32'(exp_en));
        check({tag, " busy"}, 32'(busy), 32'(|exp_en));
        if (|exp_en || r) check({tag, " owner"}, 32'(owner), 32'(exp_own));
    endtask

    task automatic apply_g(input string tag, input logic r, input logic [3:0] req,
                           input logic [3:0] exp_en, input logic [1:0] exp_own);
        rst_g     = r;
        request_g = req;
        @(posedge clk);
        #1;
        check({tag, " enable"}, 32'(enable_g), 32'(exp_en));
        check({tag, " busy"}, 32'(busy_g), 32'(|exp_en));
        if (|exp_en || r) check({tag, " owner"}, 32'(owner_g), 32'(exp_own));
    endtask

    typedef struct {
        string      tag;
        logic       rst;
        logic [3:0] req;
        logic [3:0] en;
        logic [1:0] own;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [3:0] oh;

        // Reset with all requests, release, single request, reset mid-ownership.
        vecs.push_back('{"rst1",  1'b1, 4'b1111, 4'b0000, 2'd0});
        vecs.push_back('{"rst2",  1'b1, 4'b1111, 4'b0000, 2'd0});
        vecs.push_back('{"rst3",  1'b1, 4'b1111, 4'b0000, 2'd0});
        vecs.push_back('{"rel",   1'b0, 4'b1111, 4'b0001, 2'd0});
        vecs.push_back('{"rst4",  1'b1, 4'b0000, 4'b0000, 2'd0});
        vecs.push_back('{"one_a", 1'b0, 4'b0100, 4'b0100, 2'd2});
        vecs.push_back('{"one_b", 1'b0, 4'b0100, 4'b0100, 2'd2});
        vecs.push_back('{"one_c", 1'b0, 4'b0100, 4'b0100, 2'd2});
        vecs.push_back('{"one_d", 1'b0, 4'b0000, 4'b0000, 2'd0});
        vecs.push_back('{"one_e", 1'b0, 4'b0000, 4'b0000, 2'd0});
        vecs.push_back('{"one_f", 1'b0, 4'b0000, 4'b0000, 2'd0});
        vecs.push_back('{"mid_a", 1'b0, 4'b0100, 4'b0100, 2'd2});
        vecs.push_back('{"mid_b", 1'b0, 4'b0100, 4'b0100, 2'd2});
        vecs.push_back('{"mid_r", 1'b1, 4'b0100, 4'b0000, 2'd0});
        vecs.push_back('{"mid_g", 1'b0, 4'b0100, 4'b0100, 2'd2});
        vecs.push_back('{"ptr_a", 1'b0, 4'b0000, 4'b0000, 2'd0});
        vecs.push_back('{"ptr_r", 1'b1, 4'b1001, 4'b0000, 2'd0});
        vecs.push_back('{"ptr_g", 1'b0, 4'b1001, 4'b0001, 2'd0});
        vecs.push_back('{"ptr_z", 1'b0, 4'b0000, 4'b0000, 2'd0});

        foreach (vecs[i]) begin
            apply(vecs[i].tag, vecs[i].rst, vecs[i].req, vecs[i].en, vecs[i].own);
        end

        // All requests held: grants rotate 0,1,2,3,0 with 8-cycle holds and 1-cycle gaps.
        apply("rr_rst", 1'b1, 4'b1111, 4'b0000, 2'd0);
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            for (int j = 0; j < 8; j++) begin
                apply("rr_own", 1'b0, 4'b1111, oh, 2'(k % 4));
            end
            apply("rr_gap", 1'b0, 4'b1111, 4'b0000, 2'd0);
        end

        // Sole hog is capped at 8 cycles and re-granted after one gap cycle.
        apply("hog_rst", 1'b1, 4'b0001, 4'b0000, 2'd0);
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 8; j++) begin
                apply("hog_own", 1'b0, 4'b0001, 4'b0001, 2'd0);
            end
            apply("hog_gap", 1'b0, 4'b0001, 4'b0000, 2'd0);
        end
        apply("hog_again", 1'b0, 4'b0001, 4'b0001, 2'd0);

        // GAP=3 instance: R0 drops after 2 cycles, three dead cycles before R1.
        apply_g("g3_rst", 1'b1, 4'b0000, 4'b0000, 2'd0);
        apply_g("g3_own0a", 1'b0, 4'b0011, 4'b0001, 2'd0);
        apply_g("g3_own0b", 1'b0, 4'b0011, 4'b0001, 2'd0);
        apply_g("g3_gap1", 1'b0, 4'b0010, 4'b0000, 2'd0);
        apply_g("g3_gap2", 1'b0, 4'b0010, 4'b0000, 2'd0);
        apply_g("g3_gap3", 1'b0, 4'b0010, 4'b0000, 2'd0);
        apply_g("g3_own1", 1'b0, 4'b0010, 4'b0010, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
